stat_graph: RTL
===============

STAT_GRAPH -- requirements
Module: stat_graph

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independently tallied strobe channels (1..4).
REQ-002 SHALL have parameter HISTORY_LEN, default 25: samples retained per channel.
REQ-003 SHALL have parameter LOG_SAMPLE_PIX, default 3: graph width per sample is 2^LOG_SAMPLE_PIX pixels; GRAPH_W = HISTORY_LEN << LOG_SAMPLE_PIX.
REQ-004 SHALL have parameters GRAPH_X, GRAPH_Y, GRAPH_H, defaults 800, 32, 200: origin at the top-left corner, plot height in pixels.
REQ-005 SHALL have parameter SAMPLE_PERIOD, default 32: frames per sample (power of two); COUNT_W, default 16: counter width.
REQ-006 SHALL have parameter CH_COLOR, default {12'h0F0, 12'hF00}: per-channel 12-bit point colour.
REQ-007 Ports: clk_65mhz in 1, pixel clock; rst_in in 1, asynchronous active-high reset.
REQ-008 Ports: hcount_in in 11, vcount_in in 10: current pixel position from xvga timing.
REQ-009 Ports: ch_strobe_in in NUM_CH: per-pixel event flags, e.g. is_alive, births; freeze_in in 1: suppress sampling.
REQ-010 Ports: pix_out out 12, registered graph pixel; busy_out out 1, rescale scan in progress.

Function
REQ-011 SHALL run a frame counter frame_cnt mod SAMPLE_PERIOD that increments at the last active pixel (hcount_in==SCREEN_WIDTH-1, vcount_in==SCREEN_HEIGHT-1), called EOF.
REQ-012 SHALL, when frame_cnt==0, add each ch_strobe_in bit to its channel accumulator on every active pixel (hcount_in<SCREEN_WIDTH, vcount_in<SCREEN_HEIGHT), EOF pixel included, saturating at 2^COUNT_W-1.
REQ-013 SHALL, at EOF with frame_cnt==0 and freeze_in low, write all accumulators to the history ring at wr_ptr, set that entry's valid bit, advance wr_ptr mod HISTORY_LEN, and clear the accumulators.
REQ-014 SHALL, at EOF with frame_cnt==0 and freeze_in high, discard and clear the accumulators and leave the ring, wr_ptr and valid bits unchanged; frame_cnt still advances.
REQ-015 SHALL implement FSM IDLE->ACCUM (frame_cnt==0)->COMMIT (EOF, one cycle)->SCAN->IDLE; a frozen EOF goes ACCUM->IDLE directly.
REQ-016 SHALL, in SCAN, visit one ring entry per cycle for HISTORY_LEN cycles and track the maximum over the valid entries of all channels; busy_out is high exactly during SCAN.
REQ-017 SHALL, on SCAN completion, set the 5-bit shift to the smallest s with (max>>s) < GRAPH_H (0 if no valid entries); the scale can therefore fall as well as rise.
REQ-018 SHALL change shift only at SCAN completion, which always falls inside vertical blank.
REQ-019 SHALL map plot column c = (hcount_in-GRAPH_X)>>LOG_SAMPLE_PIX to ring entry (wr_ptr+c) mod HISTORY_LEN, so the oldest sample is leftmost.
REQ-020 SHALL draw a channel point when the entry is valid and vcount_in == GRAPH_Y+GRAPH_H-1-(sample>>shift), inside the open plot rectangle; the lowest channel index wins on overlap.
REQ-021 SHALL draw axes 12'hFFF: row GRAPH_Y+GRAPH_H for hcount in [GRAPH_X, GRAPH_X+GRAPH_W); column GRAPH_X for vcount in [GRAPH_Y, GRAPH_Y+GRAPH_H]. Axes override points.
REQ-022 SHALL register pix_out with a latency of exactly one cycle from hcount_in/vcount_in; output is 0 outside the graph.

Reset
REQ-023 SHALL, on rst_in, immediately clear pix_out, busy_out, frame_cnt, the accumulators, wr_ptr, all valid bits, shift and max, and put the FSM in IDLE; this applies even mid-SCAN or mid-COMMIT.
REQ-024 SHALL treat history data contents as don't-care after reset, since valid bits gate all use.

Configuration
REQ-025 With STAT_GRAPH_GRID_EN defined, SHALL draw 12'h444 horizontal grid rows at GRAPH_Y + k*GRAPH_H/4 for k=0..3 inside the plot, below points in priority.
REQ-026 Without STAT_GRAPH_GRID_EN, no grid logic SHALL exist and grid rows render as background.

Structure
REQ-027 SCREEN_WIDTH, SCREEN_HEIGHT and a 12-bit colour typedef SHALL come from the shared common package; stat_graph-specific defaults stay local.
REQ-028 The history ring plus valid bits SHALL be a sub-module stat_history_ram, with one write port and two read ports (render, scan).

Verification
REQ-029 Drive ch0 high on 1000 pixels of frame 0, then EOF -> entry 0 = 1000, shift = 3, and the ch0 point at column 24 sits at row 32+199-125 = 106.
REQ-030 After reset, no strobes -> only the axes render; pix_out = 12'hFFF at (800,232) and 0 at (900,100).
REQ-031 Write 26 samples with values 0..25 -> the leftmost column shows 1, the rightmost shows 25, and wr_ptr wraps to 1.
REQ-032 Drop the single large sample 1000 out of history with all others at 50 -> shift returns to 0 after that SCAN.
REQ-033 freeze_in high at the sampling EOF -> wr_ptr, valid bits and pix_out are unchanged, and busy_out never rises.
REQ-034 Assert rst_in on the third SCAN cycle -> busy_out falls at once, and the next sample lands in entry 0.

Source files
------------

// File: rtl/stat_graph_pkg.sv
// Shared screen geometry, colour type and FSM encoding for the statistics graph overlay.
package stat_graph_pkg;

  localparam int SCREEN_WIDTH  = 1024;
  localparam int SCREEN_HEIGHT = 768;

  typedef logic [11:0] color_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_COMMIT,
    ST_SCAN
  } state_e;

  localparam color_t AXIS_COLOR = 12'hFFF;
  localparam color_t GRID_COLOR = 12'h444;

  // Smallest s such that (max_v >> s) fits below the plot height.
  function automatic logic [4:0] calc_shift(input logic [31:0] max_v, input int h);
    logic [4:0] s;
    s = 5'd0;
    for (int i = 31; i >= 0; i--)
      if ((max_v >> i) < 32'(h)) s = 5'(i);
    return s;
  endfunction

endpackage

// File: rtl/stat_history_ram.sv
// Sample history ring: one write port, render and scan read ports, per-entry valid bits.
module stat_history_ram
  import stat_graph_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DEPTH   = 25,
  parameter int COUNT_W = 16,
  parameter int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [AW-1:0]                   wr_addr,
  input  logic [NUM_CH-1:0][COUNT_W-1:0]  wr_data,
  input  logic [AW-1:0]                   rd_addr,
  output logic [NUM_CH-1:0][COUNT_W-1:0]  rd_data,
  output logic                            rd_valid,
  input  logic [AW-1:0]                   scan_addr,
  output logic [NUM_CH-1:0][COUNT_W-1:0]  scan_data,
  output logic                            scan_valid
);

  // Data is left unreset; valid bits gate every consumer.
  logic [NUM_CH-1:0][COUNT_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]               valid_q, valid_d;

  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;

  assign rd_data    = mem[rd_addr];
  assign rd_valid   = valid_q[rd_addr];
  assign scan_data  = mem[scan_addr];
  assign scan_valid = valid_q[scan_addr];

endmodule

// File: rtl/stat_graph.sv
// Per-channel strobe tally sampled every SAMPLE_PERIOD frames and drawn as an auto-scaled point graph.
// Optional grid rows are enabled with the STAT_GRAPH_GRID_EN macro.
module stat_graph
  import stat_graph_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int HISTORY_LEN    = 25,
  parameter int LOG_SAMPLE_PIX = 3,
  parameter int GRAPH_X        = 800,
  parameter int GRAPH_Y        = 32,
  parameter int GRAPH_H        = 200,
  parameter int SAMPLE_PERIOD  = 32,
  parameter int COUNT_W        = 16,
  parameter logic [NUM_CH-1:0][11:0] CH_COLOR = {12'h0F0, 12'hF00}
) (
  input  logic              clk_65mhz,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [NUM_CH-1:0] ch_strobe_in,
  input  logic              freeze_in,
  output logic [11:0]       pix_out,
  output logic              busy_out
);

  localparam int GRAPH_W = HISTORY_LEN << LOG_SAMPLE_PIX;
  localparam int AW      = (HISTORY_LEN > 1) ? $clog2(HISTORY_LEN) : 1;
  localparam int FC_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef logic [NUM_CH-1:0][COUNT_W-1:0] sample_t;

  logic [31:0] hx, vy;
  logic        active, eof, frame_zero, commit;

  assign hx     = 32'(hcount_in);
  assign vy     = 32'(vcount_in);
  assign active = (hx < SCREEN_WIDTH) && (vy < SCREEN_HEIGHT);
  assign eof    = (hx == SCREEN_WIDTH - 1) && (vy == SCREEN_HEIGHT - 1);

  // ---------------- frame counter and accumulators ----------------
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  sample_t         acc_q, acc_d, acc_sum;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;

  assign frame_zero = (frame_cnt_q == '0);
  assign commit     = eof && frame_zero && !freeze_in;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (eof)
      frame_cnt_d = (frame_cnt_q == FC_W'(SAMPLE_PERIOD - 1)) ? '0 : frame_cnt_q + FC_W'(1);
  end

  // acc_sum includes the current pixel so the EOF strobe lands in the committed sample.
  always_comb begin
    acc_sum = acc_q;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_strobe_in[i] && acc_q[i] != CNT_MAX) acc_sum[i] = acc_q[i] + COUNT_W'(1);
    acc_d = acc_q;
    if (frame_zero && active) acc_d = eof ? '0 : acc_sum;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (commit)
      wr_ptr_d = (wr_ptr_q == AW'(HISTORY_LEN - 1)) ? '0 : wr_ptr_q + AW'(1);
  end

  // ---------------- history ring ----------------
  logic [AW-1:0] rd_addr, scan_idx_q, scan_idx_d;
  sample_t       rd_data, scan_data;
  logic          rd_valid, scan_valid;

  stat_history_ram #(
    .NUM_CH (NUM_CH),
    .DEPTH  (HISTORY_LEN),
    .COUNT_W(COUNT_W),
    .AW     (AW)
  ) u_hist (
    .clk       (clk_65mhz),
    .rst       (rst_in),
    .wr_en     (commit),
    .wr_addr   (wr_ptr_q),
    .wr_data   (acc_sum),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .scan_addr (scan_idx_q),
    .scan_data (scan_data),
    .scan_valid(scan_valid)
  );

  // ---------------- FSM ----------------
  state_e state_q, state_d;
  logic   scan_last, scan_start, scan_run;

  assign scan_last = (scan_idx_q == AW'(HISTORY_LEN - 1));

  always_ff @(posedge clk_65mhz or posedge rst_in)
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (commit) state_d = ST_COMMIT;
                 else if (frame_zero && !eof) state_d = ST_ACCUM;
      ST_ACCUM:  if (eof) state_d = commit ? ST_COMMIT : ST_IDLE;
      ST_COMMIT: state_d = ST_SCAN;
      ST_SCAN:   if (scan_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_out   = (state_q == ST_SCAN);
    scan_start = (state_q == ST_COMMIT);
    scan_run   = (state_q == ST_SCAN);
  end

  // ---------------- rescale scan ----------------
  logic [COUNT_W-1:0] max_q, max_d, cand_max;
  logic [4:0]         shift_q, shift_d;

  always_comb begin
    cand_max = max_q;
    if (scan_valid)
      for (int i = 0; i < NUM_CH; i++)
        if (scan_data[i] > cand_max) cand_max = scan_data[i];
    max_d      = max_q;
    shift_d    = shift_q;
    scan_idx_d = scan_idx_q;
    if (scan_start) begin
      max_d      = '0;
      scan_idx_d = '0;
    end else if (scan_run) begin
      max_d      = cand_max;
      scan_idx_d = scan_idx_q + AW'(1);
      if (scan_last) shift_d = calc_shift(32'(cand_max), GRAPH_H);
    end
  end

  // ---------------- render ----------------
  logic        in_x_span, in_plot, axis_hit, pt_hit, grid_hit;
  logic [AW-1:0] col;
  logic [AW:0]   idx_sum;
  color_t      pt_color, pix_q, pix_d;

  assign in_x_span = (hx >= GRAPH_X) && (hx < GRAPH_X + GRAPH_W);
  assign in_plot   = (hx > GRAPH_X) && (hx < GRAPH_X + GRAPH_W) &&
                     (vy >= GRAPH_Y) && (vy < GRAPH_Y + GRAPH_H);
  assign axis_hit  = ((vy == GRAPH_Y + GRAPH_H) && in_x_span) ||
                     ((hx == GRAPH_X) && (vy >= GRAPH_Y) && (vy <= GRAPH_Y + GRAPH_H));

  // Column offset from wr_ptr puts the oldest sample at the left edge.
  always_comb begin
    col     = in_x_span ? AW'((hx - GRAPH_X) >> LOG_SAMPLE_PIX) : '0;
    idx_sum = {1'b0, wr_ptr_q} + {1'b0, col};
    if (idx_sum >= (AW+1)'(HISTORY_LEN)) rd_addr = AW'(idx_sum - (AW+1)'(HISTORY_LEN));
    else                                 rd_addr = idx_sum[AW-1:0];
  end

  always_comb begin
    pt_hit   = 1'b0;
    pt_color = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (rd_valid && in_plot &&
          (vy + (32'(rd_data[i]) >> shift_q) == GRAPH_Y + GRAPH_H - 1)) begin
        pt_hit   = 1'b1;
        pt_color = CH_COLOR[i];
      end
  end

`ifdef STAT_GRAPH_GRID_EN
  assign grid_hit = in_plot && ((vy == GRAPH_Y) ||
                                (vy == GRAPH_Y + (1 * GRAPH_H) / 4) ||
                                (vy == GRAPH_Y + (2 * GRAPH_H) / 4) ||
                                (vy == GRAPH_Y + (3 * GRAPH_H) / 4));
`else
  assign grid_hit = 1'b0;
`endif

  always_comb begin
    pix_d = '0;
    if (axis_hit)      pix_d = AXIS_COLOR;
    else if (pt_hit)   pix_d = pt_color;
    else if (grid_hit) pix_d = GRID_COLOR;
  end

  assign pix_out = pix_q;

  // ---------------- state registers ----------------
  always_ff @(posedge clk_65mhz or posedge rst_in)
    if (rst_in) begin
      frame_cnt_q <= '0;
      acc_q       <= '0;
      wr_ptr_q    <= '0;
      scan_idx_q  <= '0;
      max_q       <= '0;
      shift_q     <= '0;
      pix_q       <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      acc_q       <= acc_d;
      wr_ptr_q    <= wr_ptr_d;
      scan_idx_q  <= scan_idx_d;
      max_q       <= max_d;
      shift_q     <= shift_d;
      pix_q       <= pix_d;
    end

endmodule
